// File: rtl/chrom_eval_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chrom_eval_pkg
// Brief    : Shared constants for the chromosome evaluation controller:
//            FSM state encoding, memory word field positions, lane count
//            and a saturating increment helper.
// Revision : 1.0  initial release
// ============================================================================
package chrom_eval_pkg;

  // Memory word layout: [31:16] stimulus, [15:8] valid mask, [7:0] expected
  localparam int IN_LSB       = 16;
  localparam int VALID_LSB    = 8;
  localparam int EXP_LSB      = 0;
  localparam int NUM_ERR_SUMS = 8;

  // Controller state encoding
  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_ISSUE   = 3'd1;
  localparam logic [2:0] c_ST_WAIT_RD = 3'd2;
  localparam logic [2:0] c_ST_APPLY   = 3'd3;
  localparam logic [2:0] c_ST_SAMPLE  = 3'd4;
  localparam logic [2:0] c_ST_DONE    = 3'd5;
  localparam logic [2:0] c_ST_RELEASE = 3'd6;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chrom_eval_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : chrom_eval_ctrl_if
// Brief    : Bundles the HPS handshake, memory s2 port and circuit-under-
//            evaluation signals of the chromosome evaluation controller.
//            master = controller side, slave = surrounding system side.
// Revision : 1.0  initial release
// ============================================================================
interface chrom_eval_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8
);
  // HPS PIO handshake
  logic              start_processing_chrom;
  logic [31:0]       sequences_to_process;
  logic              ready_to_process;
  logic              done_processing_chrom;
  logic              done_processing_feedback;
  // Memory s2 port
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_readdata;
  // Circuit under evaluation
  logic [IN_W-1:0]   circ_in;
  logic [OUT_W-1:0]  circ_out;

  modport master (
    input  start_processing_chrom, sequences_to_process, done_processing_feedback,
           mem_readdata, circ_out,
    output ready_to_process, done_processing_chrom, mem_address, mem_chipselect,
           mem_clken, mem_write, mem_byteenable, circ_in
  );

  modport slave (
    output start_processing_chrom, sequences_to_process, done_processing_feedback,
           mem_readdata, circ_out,
    input  ready_to_process, done_processing_chrom, mem_address, mem_chipselect,
           mem_clken, mem_write, mem_byteenable, circ_in
  );

endinterface
`default_nettype wire

// File: rtl/chrom_eval_ctrl_err_accum.sv
`default_nettype none
// ============================================================================
// Module   : err_accum
// Brief    : Array of saturating 32-bit mismatch counters, one per circuit
//            output bit. i_clear zeroes all lanes (wins over i_sample);
//            i_sample adds one to every lane whose i_mism bit is set.
// Revision : 1.0  initial release
// ============================================================================
module err_accum
  import chrom_eval_pkg::*;
(
  input  wire logic                            clk,
  input  wire logic                            rst,
  input  wire logic                            i_clear,
  input  wire logic                            i_sample,
  input  wire logic [NUM_ERR_SUMS-1:0]         i_mism,
  output logic      [NUM_ERR_SUMS-1:0][31:0]   o_sums
);

  for (genvar k = 0; k < NUM_ERR_SUMS; k++) begin : g_lane
    logic [31:0] r_sum;

    // Per-lane counter: clear on a new evaluation, count mismatches on sample
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_sum <= 32'd0;
      else if (i_clear)
        r_sum <= 32'd0;
      else if (i_sample && i_mism[k])
        r_sum <= sat_inc(r_sum);
    end

    assign o_sums[k] = r_sum;
  end

endmodule
`default_nettype wire

// File: rtl/chrom_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chrom_eval_ctrl
// Brief    : Sequences evaluation of one chromosome. On an HPS start it walks
//            the stored test words, drives the circuit inputs, waits for the
//            circuit to settle, then accumulates masked output mismatches
//            into eight per-bit error sums and reports done to the HPS.
//            Optional macro CHROM_EVAL_CYCLE_COUNT_EN adds the eval_cycles
//            busy-cycle counter output.
// Revision : 1.0  initial release
// ============================================================================
module chrom_eval_ctrl
  import chrom_eval_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ADDR_W        = 14,
  parameter int IN_W          = 16,
  parameter int OUT_W         = 8
) (
  input  wire logic          clk_clk,
  input  wire logic          reset_reset,
  chrom_eval_ctrl_if.master  bus,
  output logic [31:0]        error_sum_0,
  output logic [31:0]        error_sum_1,
  output logic [31:0]        error_sum_2,
  output logic [31:0]        error_sum_3,
  output logic [31:0]        error_sum_4,
  output logic [31:0]        error_sum_5,
  output logic [31:0]        error_sum_6,
  output logic [31:0]        error_sum_7
`ifdef CHROM_EVAL_CYCLE_COUNT_EN
  ,
  output logic [31:0]        eval_cycles
`endif
);

  // Largest sequence count the address space can hold; the address never wraps
  localparam logic [31:0] c_MAX_N        = 32'd1 << ADDR_W;
  localparam logic [7:0]  c_SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);

  logic [2:0]                      r_state;
  logic [ADDR_W:0]                 r_n;
  logic [ADDR_W:0]                 r_idx;
  logic [15:0]                     r_word;
  logic [7:0]                      r_settle;
  logic [ADDR_W-1:0]               r_addr;
  logic                            r_cs;
  logic [IN_W-1:0]                 r_circ_in;

  logic [ADDR_W:0]                 w_n;
  logic [ADDR_W:0]                 w_idx_nxt;
  logic                            w_start;
  logic                            w_sample;
  logic [OUT_W-1:0]                w_mism;
  logic [NUM_ERR_SUMS-1:0][31:0]   w_sums;

  assign w_start   = (r_state == c_ST_IDLE) && bus.start_processing_chrom;
  assign w_sample  = (r_state == c_ST_SAMPLE);
  assign w_idx_nxt = r_idx + 1'b1;
  assign w_n       = (bus.sequences_to_process > c_MAX_N) ? c_MAX_N[ADDR_W:0]
                                                          : bus.sequences_to_process[ADDR_W:0];
  assign w_mism    = (bus.circ_out ^ r_word[EXP_LSB +: OUT_W]) & r_word[VALID_LSB +: OUT_W];

  // Controller FSM with its address, stimulus and settle registers
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state   <= c_ST_IDLE;
      r_n       <= '0;
      r_idx     <= '0;
      r_word    <= '0;
      r_settle  <= '0;
      r_addr    <= '0;
      r_cs      <= 1'b0;
      r_circ_in <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (bus.start_processing_chrom) begin
            r_n   <= w_n;
            r_idx <= '0;
            if (w_n == '0) begin
              r_state <= c_ST_DONE;
            end else begin
              r_state <= c_ST_ISSUE;
              r_addr  <= '0;
              r_cs    <= 1'b1;
            end
          end
        end
        c_ST_ISSUE: begin
          r_cs    <= 1'b0;
          r_state <= c_ST_WAIT_RD;
        end
        c_ST_WAIT_RD: begin
          r_word    <= bus.mem_readdata[15:0];
          r_circ_in <= bus.mem_readdata[IN_LSB +: IN_W];
          r_settle  <= '0;
          r_state   <= c_ST_APPLY;
        end
        c_ST_APPLY: begin
          if (r_settle == c_SETTLE_LAST)
            r_state <= c_ST_SAMPLE;
          else
            r_settle <= r_settle + 8'd1;
        end
        c_ST_SAMPLE: begin
          r_idx <= w_idx_nxt;
          if (w_idx_nxt == r_n) begin
            r_state <= c_ST_DONE;
          end else begin
            r_state <= c_ST_ISSUE;
            r_addr  <= w_idx_nxt[ADDR_W-1:0];
            r_cs    <= 1'b1;
          end
        end
        c_ST_DONE: begin
          if (bus.done_processing_feedback)
            r_state <= c_ST_RELEASE;
        end
        c_ST_RELEASE: begin
          // A start still held from the previous run must drop before re-arming
          if (!bus.start_processing_chrom && !bus.done_processing_feedback)
            r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.ready_to_process      = (r_state == c_ST_IDLE);
  assign bus.done_processing_chrom = (r_state == c_ST_DONE);
  assign bus.mem_address           = r_addr;
  assign bus.mem_chipselect        = r_cs;
  assign bus.mem_clken             = r_cs;
  assign bus.mem_write             = 1'b0;
  assign bus.mem_byteenable        = 4'hF;
  assign bus.circ_in               = r_circ_in;

  err_accum u_err_accum (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .i_clear  (w_start),
    .i_sample (w_sample),
    .i_mism   (w_mism[NUM_ERR_SUMS-1:0]),
    .o_sums   (w_sums)
  );

  assign error_sum_0 = w_sums[0];
  assign error_sum_1 = w_sums[1];
  assign error_sum_2 = w_sums[2];
  assign error_sum_3 = w_sums[3];
  assign error_sum_4 = w_sums[4];
  assign error_sum_5 = w_sums[5];
  assign error_sum_6 = w_sums[6];
  assign error_sum_7 = w_sums[7];

`ifdef CHROM_EVAL_CYCLE_COUNT_EN
  logic [31:0] r_eval_cycles;

  // Busy-cycle counter: cleared on start, counts every sequencing cycle
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)
      r_eval_cycles <= 32'd0;
    else if (w_start)
      r_eval_cycles <= 32'd0;
    else if ((r_state != c_ST_IDLE) && (r_state != c_ST_DONE) && (r_state != c_ST_RELEASE))
      r_eval_cycles <= sat_inc(r_eval_cycles);
  end

  assign eval_cycles = r_eval_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chrom_eval_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chrom_eval_ctrl
// Brief    : Directed self-checking bench for chrom_eval_ctrl with a small
//            one-cycle-latency memory model and a constant circuit response.
// Revision : 1.0  initial release
// ============================================================================
module tb_chrom_eval_ctrl;

  localparam int c_SETTLE = 4;
  localparam int c_SEQ_LAT = 3 + c_SETTLE;

  logic        clk;
  logic        rst;
  logic [31:0] es [0:7];
  logic [31:0] mem [0:15];
  int          n_err;
  int          n_chk;
  int          lat;
  int          pulses;
`ifdef CHROM_EVAL_CYCLE_COUNT_EN
  logic [31:0] eval_cycles;
`endif

  chrom_eval_ctrl_if #(.ADDR_W(14), .IN_W(16), .OUT_W(8)) bus_if ();

  chrom_eval_ctrl #(
    .SETTLE_CYCLES (c_SETTLE),
    .ADDR_W        (14),
    .IN_W          (16),
    .OUT_W         (8)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus_if),
    .error_sum_0 (es[0]),
    .error_sum_1 (es[1]),
    .error_sum_2 (es[2]),
    .error_sum_3 (es[3]),
    .error_sum_4 (es[4]),
    .error_sum_5 (es[5]),
    .error_sum_6 (es[6]),
    .error_sum_7 (es[7])
`ifdef CHROM_EVAL_CYCLE_COUNT_EN
    ,
    .eval_cycles (eval_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one-cycle read latency on the s2 port
  always @(posedge clk) begin
    if (bus_if.mem_chipselect && bus_if.mem_clken)
      bus_if.mem_readdata <= mem[bus_if.mem_address[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lanes set in 'lanes' must equal 'val', all other lanes zero
  task automatic check_sums(input string tag, input logic [7:0] lanes, input logic [31:0] val);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_sum%0d", tag, k), es[k], lanes[k] ? val : 32'd0);
  endtask

  // Raise start and count cycles until done, also counting chipselect cycles
  task automatic run(input int n, output int cycles, output int cs_cnt);
    bus_if.sequences_to_process   = n;
    bus_if.start_processing_chrom = 1'b1;
    cycles = 0;
    cs_cnt = 0;
    while (!bus_if.done_processing_chrom && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      if (bus_if.mem_chipselect) cs_cnt++;
    end
    check("done_seen", {31'd0, bus_if.done_processing_chrom}, 32'd1);
  endtask

  // Normal HPS acknowledge: drop start, pulse feedback, expect ready again
  task automatic release_done(input string tag);
    bus_if.start_processing_chrom   = 1'b0;
    bus_if.done_processing_feedback = 1'b1;
    @(negedge clk);
    check({tag, "_done_drop"}, {31'd0, bus_if.done_processing_chrom}, 32'd0);
    bus_if.done_processing_feedback = 1'b0;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, bus_if.ready_to_process}, 32'd1);
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    rst = 1'b1;
    bus_if.start_processing_chrom   = 1'b0;
    bus_if.sequences_to_process     = 32'd0;
    bus_if.done_processing_feedback = 1'b0;
    bus_if.circ_out                 = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", {31'd0, bus_if.ready_to_process}, 32'd1);
    check("rst_done", {31'd0, bus_if.done_processing_chrom}, 32'd0);
    check("rst_cs", {31'd0, bus_if.mem_chipselect}, 32'd0);
    check("rst_clken", {31'd0, bus_if.mem_clken}, 32'd0);
    check("rst_addr", {18'd0, bus_if.mem_address}, 32'd0);
    check("rst_circ_in", {16'd0, bus_if.circ_in}, 32'd0);
    check("rst_write", {31'd0, bus_if.mem_write}, 32'd0);
    check("rst_be", {28'd0, bus_if.mem_byteenable}, 32'hF);
    check_sums("rst", 8'h00, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // T1: single matching sequence
    mem[0] = 32'hABCD_FF5A;
    bus_if.circ_out = 8'h5A;
    run(1, lat, pulses);
    check("t1_latency", lat, 32'(1 * c_SEQ_LAT + 1));
    check("t1_cs_pulses", pulses, 32'd1);
    check("t1_circ_in", {16'd0, bus_if.circ_in}, 32'h0000_ABCD);
    check_sums("t1", 8'h00, 32'd0);
`ifdef CHROM_EVAL_CYCLE_COUNT_EN
    check("t1_eval_cycles", eval_cycles, 32'd7);
`endif
    release_done("t1");

    // T2: four sequences, outputs 0x81 against expected 0x00, full mask
    for (int i = 0; i < 4; i++) mem[i] = {16'h2000 + 16'(i), 16'hFF00};
    bus_if.circ_out = 8'h81;
    run(4, lat, pulses);
    check("t2_latency", lat, 32'(4 * c_SEQ_LAT + 1));
    check("t2_cs_pulses", pulses, 32'd4);
    check("t2_circ_in", {16'd0, bus_if.circ_in}, 32'h0000_2003);
    check_sums("t2", 8'h81, 32'd4);
    release_done("t2");

    // T3: valid mask 0x0F, expected 0x00, outputs 0xFF, three sequences
    for (int i = 0; i < 3; i++) mem[i] = {16'h3000 + 16'(i), 16'h0F00};
    bus_if.circ_out = 8'hFF;
    run(3, lat, pulses);
    check("t3_latency", lat, 32'(3 * c_SEQ_LAT + 1));
    check_sums("t3", 8'h0F, 32'd3);
    release_done("t3");

    // T4: zero sequences -> immediate done, sums cleared, no memory access
    run(0, lat, pulses);
    check("t4_latency", lat, 32'd1);
    check("t4_cs_pulses", pulses, 32'd0);
    check_sums("t4", 8'h00, 32'd0);
    check("t4_circ_in_hold", {16'd0, bus_if.circ_in}, 32'h0000_3002);
`ifdef CHROM_EVAL_CYCLE_COUNT_EN
    check("t4_eval_cycles", eval_cycles, 32'd0);
`endif
    release_done("t4");

    // T5: start held through done; feedback pulse must not re-trigger a run
    mem[0] = {16'h5555, 16'hFF00};
    bus_if.circ_out = 8'h81;
    run(1, lat, pulses);
    bus_if.done_processing_feedback = 1'b1;
    @(negedge clk);
    check("t5_done_drop", {31'd0, bus_if.done_processing_chrom}, 32'd0);
    bus_if.done_processing_feedback = 1'b0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus_if.mem_chipselect) pulses++;
    end
    check("t5_no_retrigger_cs", pulses, 32'd0);
    check("t5_ready_low", {31'd0, bus_if.ready_to_process}, 32'd0);
    check("t5_done_low", {31'd0, bus_if.done_processing_chrom}, 32'd0);
    bus_if.start_processing_chrom = 1'b0;
    @(negedge clk);
    check("t5_ready", {31'd0, bus_if.ready_to_process}, 32'd1);
    check_sums("t5", 8'h81, 32'd1);

    // T6: reset during APPLY of sequence 2 of 5, then a clean N=2 run
    for (int i = 0; i < 5; i++) mem[i] = {16'h1000 + 16'(i), 16'hFF00};
    bus_if.sequences_to_process   = 32'd5;
    bus_if.start_processing_chrom = 1'b1;
    repeat (2 * c_SEQ_LAT - 4) @(negedge clk);
    check("t6_mid_circ_in", {16'd0, bus_if.circ_in}, 32'h0000_1001);
    check("t6_mid_sum0", es[0], 32'd1);
    bus_if.start_processing_chrom = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_ready", {31'd0, bus_if.ready_to_process}, 32'd1);
    check("t6_rst_circ_in", {16'd0, bus_if.circ_in}, 32'd0);
    check("t6_rst_addr", {18'd0, bus_if.mem_address}, 32'd0);
    check("t6_rst_cs", {31'd0, bus_if.mem_chipselect}, 32'd0);
    check_sums("t6_rst", 8'h00, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(2, lat, pulses);
    check("t6_latency", lat, 32'(2 * c_SEQ_LAT + 1));
    check_sums("t6", 8'h81, 32'd2);
    release_done("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chrom_eval_ctrl.md
Name: chrom_eval_ctrl

Overview:
- Sequences evaluation of one chromosome on the evolvable-circuit datapath.
- On an HPS start request it walks the stored test sequences in the dual-port memory one at a time. For each sequence it reads the memory word, drives the circuit inputs, waits for the circuit to settle, then compares the circuit outputs against the expected bits under the valid mask.
- Mismatches are accumulated into 8 per-output-bit error sums, and completion is reported to the HPS through the done/feedback handshake.
- Sits between the HPS PIO block, the memory s2 port and the circuit under evaluation.

Parameters:
- SETTLE_CYCLES, 4, cycles the circuit inputs are held before outputs are sampled; legal range 1..255.
- ADDR_W, 14, memory word address width.
- IN_W, 16, circuit input vector width; occupies memory word bits [31:16].
- OUT_W, 8, circuit output width; expected value in bits [7:0], valid mask in bits [15:8].

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- start_processing_chrom  in  1  HPS start request (level).
- sequences_to_process  in  32  number of sequences; sampled on start.
- ready_to_process  out  1  high only in IDLE.
- done_processing_chrom  out  1  evaluation complete; results valid.
- done_processing_feedback  in  1  HPS acknowledge of done.
- mem_address  out  ADDR_W  memory s2 word address.
- mem_chipselect  out  1  memory select.
- mem_clken  out  1  memory clock enable.
- mem_write  out  1  tied 0.
- mem_byteenable  out  4  tied 4'hF.
- mem_readdata  in  32  read data, 1-cycle latency.
- circ_in  out  IN_W  registered stimulus to the circuit.
- circ_out  in  OUT_W  circuit response.
- error_sum_0 .. error_sum_7  out  32 each  mismatch count for output bit k.

Behaviour:
- Reset (async, active-high):
  - state = IDLE; ready = 1; done = 0; chipselect = 0; clken = 0; address = 0; circ_in = 0; all error sums = 0; counters = 0.
  - Reset asserted mid-operation aborts immediately. The next evaluation starts with cleared sums.
- FSM states: IDLE, ISSUE, WAIT_RD, APPLY, SAMPLE, DONE, RELEASE.
- IDLE:
  - On start = 1: latch N = min(sequences_to_process, 2^ADDR_W), clear sums and index i, ready <= 0.
  - If N = 0, go to DONE; otherwise go to ISSUE.
- ISSUE: address = i, chipselect = 1, clken = 1 for exactly one cycle; then WAIT_RD.
- WAIT_RD: capture mem_readdata into an internal word register; chipselect = 0, clken = 0; then APPLY.
- APPLY:
  - circ_in <= word[31:16] on entry.
  - Settle counter counts SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE:
  - mism = (circ_out XOR word[7:0]) AND word[15:8].
  - For each k with mism[k] = 1, error_sum_k += 1, saturating at 32'hFFFFFFFF.
  - i += 1. If i = N go to DONE, else go to ISSUE.
- Per-sequence latency: 3 + SETTLE_CYCLES cycles. Total cycles from start to done = N*(3+SETTLE_CYCLES) + 1.
- DONE:
  - done = 1; error sums stable and held.
  - Remains in DONE until feedback = 1, then RELEASE.
- RELEASE:
  - done = 0.
  - Waits until start = 0 and feedback = 0, then IDLE with ready = 1.
  - This prevents a held start from re-triggering an evaluation.
- Further rules:
  - start is ignored outside IDLE.
  - sequences_to_process changes after sampling are ignored.
  - circ_in holds its last value after DONE.
  - error sums are held until the next start.
  - The address never wraps; N is clamped to 2^ADDR_W.
  - If feedback = 1 already on DONE entry, done is high for exactly one cycle.

Optional Feature:
- CHROM_EVAL_CYCLE_COUNT_EN defined:
  - Adds output eval_cycles (32 bits).
  - Cleared on start and incremented every cycle outside IDLE/DONE/RELEASE, saturating.
  - Holds its value in DONE.
  - Reset value 0.
- Not defined: the port and the counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package chrom_eval_pkg holds:
  - the FSM state enum;
  - memory word field constants (IN_LSB = 16, VALID_LSB = 8, EXP_LSB = 0);
  - constant NUM_ERR_SUMS = 8.
- One sub-module, err_accum: the 8-lane saturating mismatch counter array. Inputs are the clear pulse, the sample strobe and mism; outputs are the sums.

Test Plan:
- N=1, word = 32'hABCD_FF5A, circ_out = 8'h5A -> circ_in = 16'hABCD; all sums 0; done asserted 4+SETTLE_CYCLES cycles after start.
- N=4, all words expected 8'h00 with valid 8'hFF, circ_out = 8'h81 constant -> error_sum_0 = error_sum_7 = 4, others 0.
- Valid mask 8'h0F, expected 8'h00, circ_out = 8'hFF, N=3 -> error_sum_0..3 = 3, error_sum_4..7 = 0.
- sequences_to_process = 0 -> done one cycle after start; sums 0; no memory chipselect pulses.
- Start held high through DONE and feedback pulsed -> done drops, no new run until start = 0, then ready = 1; sums held.
- Reset asserted during APPLY of sequence 2 of 5 -> immediate IDLE with all outputs at reset values; a new start with N=2 yields a correct count from zero.
